// File: rtl/reward_engine.sv
// reward_engine: queues reward requests, scans the neighbour table for the best next-hop Q, emits REWARD packets
// Optional feature macro: REWARD_ENERGY_WEIGHT_EN (rQValue = bestQ/2 + myEnergy/2); default build passes bestQ.
// Ports: clk/rst (async active-high); en/fPacketType/fSourceID/iAmDestination push requests;
//   own node info (myNodeID, myEnergy, myQValue, hopsFromSink, role, chosenCH, hopsFromCH);
//   nTableCount/nTableIndex_reward/mNode* neighbour-table read (1-cycle latency);
//   r* packet fields with reward_valid/reward_ready handshake; req_full/req_drop request-FIFO status.
module reward_engine #(
  parameter int         WORD_WIDTH = 16,
  parameter int         NT_DEPTH   = 32,
  parameter int         REQ_DEPTH  = 4,
  parameter logic [2:0] PKT_DATA   = 3'b011,
  parameter logic [2:0] PKT_REWARD = 3'b100,
  parameter int         IDXW       = $clog2(NT_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [2:0]            fPacketType,
  input  logic [WORD_WIDTH-1:0] fSourceID,
  input  logic                  iAmDestination,
  input  logic [WORD_WIDTH-1:0] myNodeID,
  input  logic [WORD_WIDTH-1:0] myEnergy,
  input  logic [WORD_WIDTH-1:0] myQValue,
  input  logic [WORD_WIDTH-1:0] hopsFromSink,
  input  logic                  role,
  input  logic [WORD_WIDTH-1:0] chosenCH,
  input  logic [WORD_WIDTH-1:0] hopsFromCH,
  input  logic [IDXW:0]         nTableCount,
  output logic [IDXW-1:0]       nTableIndex_reward,
  input  logic [WORD_WIDTH-1:0] mNodeID,
  input  logic [WORD_WIDTH-1:0] mNodeQValue,
  input  logic [WORD_WIDTH-1:0] mNodeHops,
  output logic [WORD_WIDTH-1:0] rSourceID,
  output logic [WORD_WIDTH-1:0] rEnergyLeft,
  output logic [WORD_WIDTH-1:0] rQValue,
  output logic [WORD_WIDTH-1:0] rSourceHops,
  output logic [WORD_WIDTH-1:0] rDestinationID,
  output logic [WORD_WIDTH-1:0] rChosenCH,
  output logic [WORD_WIDTH-1:0] rHopsFromCH,
  output logic [2:0]            rPacketType,
  output logic                  reward_valid,
  input  logic                  reward_ready,
  output logic                  req_full,
  output logic                  req_drop
);
  localparam int WW = WORD_WIDTH;
  localparam int AW = $clog2(REQ_DEPTH);
  typedef enum logic [1:0] {IDLE, SCAN, BUILD, DONE} state_t;
  state_t          state_q, state_d;
  logic [WW-1:0]   mem_q [REQ_DEPTH];
  logic [AW-1:0]   wp_q, rp_q;
  logic [AW:0]     fcnt_q;
  logic            push, wr, pop;
  logic [IDXW:0]   ncnt_q, k_q, ncnt_clamp;
  logic [IDXW-1:0] idx_q;
  logic [WW-1:0]   best_q, q_fin;
  logic [WW-1:0]   src_q, nrg_q, qv_q, hops_q, dst_q, ch_q, hch_q;
  logic [2:0]      type_q;
  logic            unused_ok;
  assign unused_ok = ^{myQValue, mNodeID};
  assign push = en && iAmDestination && fPacketType == PKT_DATA;
  assign req_full = fcnt_q == (AW+1)'(REQ_DEPTH);
  // a full FIFO still accepts a push when the head is popped in the same cycle
  assign wr = push && (!req_full || pop);
  assign req_drop = push && req_full && !pop;
  assign ncnt_clamp = nTableCount > (IDXW+1)'(NT_DEPTH) ? (IDXW+1)'(NT_DEPTH) : nTableCount;
`ifdef REWARD_ENERGY_WEIGHT_EN
  assign q_fin = (best_q >> 1) + (myEnergy >> 1);
`else
  assign q_fin = best_q;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
      fcnt_q <= '0;
    end else begin
      if (wr) wp_q <= wp_q + AW'(1);
      if (pop) rp_q <= rp_q + AW'(1);
      fcnt_q <= fcnt_q + (AW+1)'(wr) - (AW+1)'(pop);
    end
  always_ff @(posedge clk)
    if (wr) mem_q[wp_q] <= fSourceID;
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  // an empty table still takes one scan cycle, keeping push->valid latency at count+3
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = fcnt_q != '0 ? SCAN : IDLE;
      SCAN:    state_d = k_q == ncnt_q ? BUILD : SCAN;
      BUILD:   state_d = DONE;
      DONE:    state_d = reward_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    reward_valid = state_q == DONE;
    pop = reward_valid && reward_ready;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ncnt_q <= '0;
      k_q <= '0;
      idx_q <= '0;
      best_q <= '0;
      src_q <= '0;
      nrg_q <= '0;
      qv_q <= '0;
      hops_q <= '1;
      dst_q <= '0;
      ch_q <= '0;
      hch_q <= '1;
      type_q <= '0;
    end else begin
      if (state_q == IDLE) begin
        ncnt_q <= ncnt_clamp;
        k_q <= '0;
        best_q <= '0;
        idx_q <= '0;
      end
      // cycle k drives index k and evaluates the data returned for index k-1
      if (state_q == SCAN) begin
        k_q <= k_q + (IDXW+1)'(1);
        if (k_q + (IDXW+1)'(1) < ncnt_q) idx_q <= idx_q + IDXW'(1);
        if (k_q != '0 && mNodeHops < hopsFromSink && mNodeQValue > best_q) best_q <= mNodeQValue;
      end
      if (state_q == BUILD) begin
        src_q <= myNodeID;
        nrg_q <= myEnergy;
        qv_q <= q_fin;
        hops_q <= hopsFromSink;
        dst_q <= mem_q[rp_q];
        ch_q <= role ? myNodeID : chosenCH;
        hch_q <= role ? '0 : hopsFromCH;
        type_q <= PKT_REWARD;
      end
      if (pop) idx_q <= '0;
    end
  assign nTableIndex_reward = idx_q;
  assign rSourceID = src_q;
  assign rEnergyLeft = nrg_q;
  assign rQValue = qv_q;
  assign rSourceHops = hops_q;
  assign rDestinationID = dst_q;
  assign rChosenCH = ch_q;
  assign rHopsFromCH = hch_q;
  assign rPacketType = type_q;
endmodule

// File: tb/tb_reward_engine.sv
// tb_reward_engine: randomized and directed checks of reward_engine against a table-scan reference model
module tb_reward_engine;
  localparam int WW = 16;
  localparam int NT = 32;
  localparam int IDXW = 5;
  logic clk = 0, rst = 1, en = 0, iAmDestination = 0, role = 0, reward_ready = 0;
  logic [2:0] fPacketType = 0;
  logic [WW-1:0] fSourceID = 0, myNodeID = 0, myEnergy = 0, myQValue = 0, hopsFromSink = 0;
  logic [WW-1:0] chosenCH = 0, hopsFromCH = 0, mNodeID = 0, mNodeQValue = 0, mNodeHops = 0;
  logic [IDXW:0] nTableCount = 0;
  logic [IDXW-1:0] nTableIndex_reward;
  logic [WW-1:0] rSourceID, rEnergyLeft, rQValue, rSourceHops, rDestinationID, rChosenCH, rHopsFromCH;
  logic [2:0] rPacketType;
  logic reward_valid, req_full, req_drop;
  int tests = 0, failed = 0;
  logic [WW-1:0] tq [NT];
  logic [WW-1:0] th [NT];
  wire [7*WW+2:0] dut_pkt = {rSourceID, rEnergyLeft, rQValue, rSourceHops, rDestinationID, rChosenCH, rHopsFromCH, rPacketType};

  reward_engine dut (
    .clk(clk), .rst(rst), .en(en), .fPacketType(fPacketType), .fSourceID(fSourceID),
    .iAmDestination(iAmDestination), .myNodeID(myNodeID), .myEnergy(myEnergy), .myQValue(myQValue),
    .hopsFromSink(hopsFromSink), .role(role), .chosenCH(chosenCH), .hopsFromCH(hopsFromCH),
    .nTableCount(nTableCount), .nTableIndex_reward(nTableIndex_reward), .mNodeID(mNodeID),
    .mNodeQValue(mNodeQValue), .mNodeHops(mNodeHops), .rSourceID(rSourceID), .rEnergyLeft(rEnergyLeft),
    .rQValue(rQValue), .rSourceHops(rSourceHops), .rDestinationID(rDestinationID), .rChosenCH(rChosenCH),
    .rHopsFromCH(rHopsFromCH), .rPacketType(rPacketType), .reward_valid(reward_valid),
    .reward_ready(reward_ready), .req_full(req_full), .req_drop(req_drop)
  );

  always #5 clk = ~clk;

  // neighbour table with one-cycle read latency
  always @(posedge clk) begin
    mNodeQValue <= tq[nTableIndex_reward];
    mNodeHops <= th[nTableIndex_reward];
    mNodeID <= WW'(nTableIndex_reward);
  end

  function automatic int eff_count();
    return nTableCount > NT ? NT : int'(nTableCount);
  endfunction

  function automatic logic [7*WW+2:0] exp_pkt(input logic [WW-1:0] src);
    logic [WW-1:0] best, q;
    best = 0;
    for (int i = 0; i < eff_count(); i++)
      if (th[i] < hopsFromSink && tq[i] > best) best = tq[i];
`ifdef REWARD_ENERGY_WEIGHT_EN
    q = best / 2 + myEnergy / 2;
`else
    q = best;
`endif
    return {myNodeID, myEnergy, q, hopsFromSink, src, role ? myNodeID : chosenCH, role ? WW'(0) : hopsFromCH, 3'b100};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [WW-1:0] src);
    en = 1;
    fPacketType = 3'b011;
    iAmDestination = 1;
    fSourceID = src;
    tick();
    en = 0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!reward_valid && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    tests++;
    if ({reward_valid, req_full, req_drop, nTableIndex_reward} !== '0) begin
      failed++;
      $display("FAIL reset_ctrl got v=%b f=%b d=%b idx=%0d want 0", reward_valid, req_full, req_drop, nTableIndex_reward);
    end
    tests++;
    if (dut_pkt !== {16'h0, 16'h0, 16'h0, 16'hffff, 16'h0, 16'h0, 16'hffff, 3'b000}) begin
      failed++;
      $display("FAIL reset_fields got %h", dut_pkt);
    end
  endtask

  task automatic test_example();
    int lat;
    nTableCount = 3;
    tq[0] = 16'h10; tq[1] = 16'h40; tq[2] = 16'h40;
    th[0] = 0; th[1] = 0; th[2] = 0;
    hopsFromSink = 1; myNodeID = 16'h0021; myEnergy = 16'h1234; chosenCH = 16'h0007; hopsFromCH = 2; role = 0;
    send(16'h0005);
    wait_valid(lat);
    tests++;
    if (lat !== 6) begin failed++; $display("FAIL example_latency got %0d want 6", lat); end
    tests++;
    if ({rDestinationID, rPacketType} !== {16'h0005, 3'b100}) begin
      failed++;
      $display("FAIL example_dst_type got %h/%b want 0005/100", rDestinationID, rPacketType);
    end
`ifndef REWARD_ENERGY_WEIGHT_EN
    tests++;
    if (rQValue !== 16'h40) begin failed++; $display("FAIL example_q got %h want 0040", rQValue); end
`endif
    tests++;
    if (dut_pkt !== exp_pkt(16'h0005)) begin failed++; $display("FAIL example_pkt got %h want %h", dut_pkt, exp_pkt(16'h0005)); end
    tests++;
    if (nTableIndex_reward !== 2) begin failed++; $display("FAIL example_idx_hold got %0d want 2", nTableIndex_reward); end
    reward_ready = 1;
    tick();
    reward_ready = 0;
    tests++;
    if ({reward_valid, nTableIndex_reward} !== '0) begin
      failed++;
      $display("FAIL example_release got v=%b idx=%0d want 0/0", reward_valid, nTableIndex_reward);
    end
  endtask

  task automatic test_empty_table();
    int lat;
    nTableCount = 0;
    myEnergy = 16'h8000;
    send(16'h0abc);
    wait_valid(lat);
    tests++;
    if (lat !== 3) begin failed++; $display("FAIL empty_latency got %0d want 3", lat); end
    tests++;
`ifdef REWARD_ENERGY_WEIGHT_EN
    if (rQValue !== 16'h4000) begin failed++; $display("FAIL empty_q got %h want 4000", rQValue); end
`else
    if (rQValue !== 16'h0000) begin failed++; $display("FAIL empty_q got %h want 0000", rQValue); end
`endif
    reward_ready = 1;
    tick();
    reward_ready = 0;
  endtask

  task automatic test_cluster_head();
    int lat;
    nTableCount = 2;
    role = 1;
    myNodeID = 16'h000c;
    chosenCH = 16'h0099;
    hopsFromCH = 16'h0005;
    send(16'h0031);
    wait_valid(lat);
    tests++;
    if ({rChosenCH, rHopsFromCH} !== {16'h000c, 16'h0000}) begin
      failed++;
      $display("FAIL ch_fields got %h/%h want 000c/0000", rChosenCH, rHopsFromCH);
    end
    reward_ready = 1;
    tick();
    reward_ready = 0;
    role = 0;
  endtask

  task automatic test_random();
    int lat;
    logic [WW-1:0] src;
    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < NT; i++) begin
        tq[i] = WW'($urandom_range(0, 255));
        th[i] = WW'($urandom_range(0, 8));
      end
      nTableCount = (IDXW+1)'($urandom_range(0, 36));
      hopsFromSink = WW'($urandom_range(1, 8));
      myNodeID = WW'($urandom); myEnergy = WW'($urandom); chosenCH = WW'($urandom);
      hopsFromCH = WW'($urandom); role = 1'($urandom_range(0, 1));
      src = WW'($urandom);
      send(src);
      wait_valid(lat);
      tests++;
      if (lat !== eff_count() + 3) begin failed++; $display("FAIL rand_latency[%0d] got %0d want %0d", n, lat, eff_count() + 3); end
      tests++;
      if (dut_pkt !== exp_pkt(src)) begin failed++; $display("FAIL rand_pkt[%0d] got %h want %h", n, dut_pkt, exp_pkt(src)); end
      tests++;
      if (nTableIndex_reward !== IDXW'(eff_count() == 0 ? 0 : eff_count() - 1)) begin
        failed++;
        $display("FAIL rand_idx[%0d] got %0d want %0d", n, nTableIndex_reward, eff_count() == 0 ? 0 : eff_count() - 1);
      end
      reward_ready = 1;
      tick();
      reward_ready = 0;
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    nTableCount = 2;
    hopsFromSink = 4;
    for (int k = 0; k < 5; k++) begin
      en = 1; fPacketType = 3'b011; iAmDestination = 1; fSourceID = WW'(16'h0100 + k);
      tests++;
      if (req_drop !== (k == 4)) begin failed++; $display("FAIL b2b_drop[%0d] got %b want %b", k, req_drop, k == 4); end
      tick();
    end
    en = 0;
    tests++;
    if (req_full !== 1'b1) begin failed++; $display("FAIL b2b_full got %b want 1", req_full); end
    wait_valid(lat);
    for (int c = 0; c < 10; c++) begin
      tests++;
      if ({reward_valid, dut_pkt} !== {1'b1, exp_pkt(16'h0100)}) begin
        failed++;
        $display("FAIL b2b_stable[%0d] got v=%b %h want %h", c, reward_valid, dut_pkt, exp_pkt(16'h0100));
      end
      tick();
    end
    reward_ready = 1;
    for (int j = 0; j < 4; j++) begin
      wait_valid(lat);
      tests++;
      if ({reward_valid, dut_pkt} !== {1'b1, exp_pkt(WW'(16'h0100 + j))}) begin
        failed++;
        $display("FAIL b2b_order[%0d] got v=%b %h want %h", j, reward_valid, dut_pkt, exp_pkt(WW'(16'h0100 + j)));
      end
      tick();
    end
    reward_ready = 0;
    repeat (10) tick();
    tests++;
    if ({reward_valid, req_full} !== 2'b00) begin failed++; $display("FAIL b2b_drained got v=%b f=%b want 0/0", reward_valid, req_full); end
  endtask

  task automatic test_filter();
    int seen;
    en = 1; iAmDestination = 1; fPacketType = 3'b001; fSourceID = 16'h0077;
    tick();
    iAmDestination = 0; fPacketType = 3'b011;
    tick();
    en = 0;
    seen = 0;
    repeat (15) begin
      if (reward_valid || nTableIndex_reward != 0) seen++;
      tick();
    end
    tests++;
    if (seen !== 0) begin failed++; $display("FAIL filter_no_push got %0d active cycles want 0", seen); end
  endtask

  task automatic test_reset_mid_scan();
    int seen;
    nTableCount = 20;
    hopsFromSink = 8;
    for (int k = 0; k < 3; k++) begin
      en = 1; fPacketType = 3'b011; iAmDestination = 1; fSourceID = WW'(16'h0200 + k);
      tick();
    end
    en = 0;
    repeat (3) tick();
    tests++;
    if (nTableIndex_reward !== 4) begin failed++; $display("FAIL scan_progress got %0d want 4", nTableIndex_reward); end
    #2 rst = 1;
    #1;
    tests++;
    if ({reward_valid, nTableIndex_reward, rSourceHops} !== {1'b0, 5'd0, 16'hffff}) begin
      failed++;
      $display("FAIL midscan_reset got v=%b idx=%0d hops=%h want 0/0/ffff", reward_valid, nTableIndex_reward, rSourceHops);
    end
    tick();
    rst = 0;
    seen = 0;
    repeat (40) begin
      if (reward_valid || nTableIndex_reward != 0) seen++;
      tick();
    end
    tests++;
    if (seen !== 0) begin failed++; $display("FAIL midscan_fifo_flushed got %0d active cycles want 0", seen); end
  endtask

  initial begin
    for (int i = 0; i < NT; i++) begin
      tq[i] = 0;
      th[i] = 0;
    end
    repeat (3) tick();
    test_reset();
    rst = 0;
    tick();
    test_reset();
    test_example();
    test_empty_table();
    test_cluster_head();
    test_filter();
    test_random();
    test_back_to_back();
    test_reset_mid_scan();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
